// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed driver for common-anode 7-segment digits.
// One digit is lit per slot, with a dark guard interval at each slot start to
// stop the previous digit from ghosting. Hex digits are double-buffered, and new
// values only reach the display at frame wrap so the display never tears.
module seg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 16,
    parameter int AN_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank,
    output logic [DIGITS-1:0]     an,
    output logic [0:6]            seg,
    output logic                  dp_n,
    output logic                  frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] AN_OFF = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [0:6] SEG_OFF = 7'b1111111;

    logic [CW-1:0]         div_cnt;
    logic [DW-1:0]         dig;
    logic [4*DIGITS-1:0]   disp_buf, pend_buf;
    logic [DIGITS-1:0]     disp_dp, pend_dp;
    logic                  pend;
    logic                  slot_end, wrap, xfer;
    logic [DIGITS-1:0]     blank;
    logic [DIGITS-1:0]     an_hot;
    logic [3:0]            nib;

    // Segment pattern for one hex nibble, a..g, active-low.
    function automatic logic [0:6] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    assign slot_end = (div_cnt == CW'(SCAN_DIV - 1));
    assign wrap     = enable && slot_end && (dig == DW'(DIGITS - 1));
    // While dark, a pending value moves straight through so re-enable shows it.
    assign xfer     = pend && (wrap || !enable);
    assign nib      = disp_buf[4*dig +: 4];
    assign an_hot   = DIGITS'(1) << dig;

    // A digit blanks when it and every more-significant digit are zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (disp_buf[4*i +: 4] == 4'h0);
            blank[i] = lz_blank && (i != 0) && all_zero;
        end
    end

    // Slot prescaler and digit pointer; both held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            dig     <= '0;
        end else if (!enable) begin
            div_cnt <= '0;
            dig     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            dig     <= (dig == DW'(DIGITS - 1)) ? '0 : dig + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Pending/display double buffer; a load on the transfer edge stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_buf <= '0;
            pend_dp  <= '0;
            pend     <= 1'b0;
            disp_buf <= '0;
            disp_dp  <= '0;
        end else begin
            if (load) begin
                pend_buf <= value;
                pend_dp  <= dp_in;
            end
            if (xfer) begin
                disp_buf <= pend_buf;
                disp_dp  <= pend_dp;
                pend     <= load;
            end else if (load) begin
                pend     <= 1'b1;
            end
        end
    end

    // Registered pin drive, computed from the pre-edge scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (!enable || (div_cnt < CW'(GUARD))) begin
                an   <= AN_OFF;
                seg  <= SEG_OFF;
                dp_n <= 1'b1;
            end else begin
                an   <= (AN_ACT_LOW != 0) ? ~an_hot : an_hot;
                seg  <= blank[dig] ? SEG_OFF : glyph(nib);
                dp_n <= ~disp_dp[dig];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at DIGITS=4, SCAN_DIV=8, GUARD=2.
module tb_seg_scan_driver;

    logic        clk, rst_n, enable, load, lz_blank;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [0:6]  seg;
    logic        dp_n, frame_tick;
    int          checks = 0;
    int          errors = 0;

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .GUARD(2), .AN_ACT_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .lz_blank(lz_blank), .an(an), .seg(seg), .dp_n(dp_n),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Leaves us at the negedge of the cycle where frame_tick is high.
    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 100);
        if (frame_tick !== 1'b1) chk("ft_timeout", 32'(frame_tick), 32'd1);
    endtask

    // Observe slot s, prescaler count d of the next frame.
    task automatic sample(input string tag, input int s, input int d,
                          input logic [3:0] ean, input logic [6:0] eseg, input logic edp);
        wait_frame();
        repeat (s*8 + d + 1) @(negedge clk);
        chk({tag, "_an"}, 32'(an), 32'(ean));
        chk({tag, "_seg"}, 32'(seg), 32'(eseg));
        chk({tag, "_dp"}, 32'(dp_n), 32'(edp));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame();
    endtask

    initial begin
        int n;
        rst_n = 0; enable = 0; load = 0; value = '0; dp_in = '0; lz_blank = 0;
        #12;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'd1);
        chk("rst_ft", 32'(frame_tick), 32'd0);

        // first value, shown after the first frame wrap
        @(negedge clk);
        rst_n = 1; enable = 1; load = 1; value = 16'h12AF;
        @(negedge clk);
        load = 0;
        sample("g0", 0, 0, 4'b1111, 7'b1111111, 1'b1);
        sample("g1", 0, 1, 4'b1111, 7'b1111111, 1'b1);
        sample("d0", 0, 2, 4'b1110, 7'b0111000, 1'b1);
        sample("d0e", 0, 7, 4'b1110, 7'b0111000, 1'b1);
        sample("d1", 1, 2, 4'b1101, 7'b0001000, 1'b1);
        sample("d2", 2, 5, 4'b1011, 7'b0010010, 1'b1);
        sample("d3", 3, 2, 4'b0111, 7'b1001111, 1'b1);
        sample("d3g", 3, 1, 4'b1111, 7'b1111111, 1'b1);

        // frame length
        wait_frame();
        n = 0;
        do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 100);
        chk("frame_len", 32'(n), 32'd32);

        // leading-zero blanking
        lz_blank = 1;
        do_load(16'h0030, 4'b0000);
        sample("lz3", 3, 3, 4'b0111, 7'b1111111, 1'b1);
        sample("lz2", 2, 3, 4'b1011, 7'b1111111, 1'b1);
        sample("lz1", 1, 3, 4'b1101, 7'b0000110, 1'b1);
        sample("lz0", 0, 3, 4'b1110, 7'b0000001, 1'b1);
        lz_blank = 0;
        sample("nolz3", 3, 3, 4'b0111, 7'b0000001, 1'b1);

        // two loads mid-frame: current frame untouched, last one wins next frame
        wait_frame();
        repeat (5) @(negedge clk);
        load = 1; value = 16'h1111;
        @(negedge clk); load = 0;
        repeat (4) @(negedge clk);
        load = 1; value = 16'h2222;
        @(negedge clk); load = 0;
        repeat (17) @(negedge clk);
        chk("db_cur_an", 32'(an), 32'b0111);
        chk("db_cur_seg", 32'(seg), 32'b0000001);
        sample("db_nx0", 0, 3, 4'b1110, 7'b0010010, 1'b1);
        sample("db_nx3", 3, 3, 4'b0111, 7'b0010010, 1'b1);

        // load in the boundary cycle while another is pending
        wait_frame();
        repeat (10) @(negedge clk);
        load = 1; value = 16'h4444;
        @(negedge clk); load = 0;
        repeat (20) @(negedge clk);
        load = 1; value = 16'h5555;
        @(negedge clk); load = 0;
        chk("bnd_ft", 32'(frame_tick), 32'd1);
        repeat (4) @(negedge clk);
        chk("bnd_4_an", 32'(an), 32'b1110);
        chk("bnd_4_seg", 32'(seg), 32'b1001100);
        sample("bnd_5", 0, 3, 4'b1110, 7'b0100100, 1'b1);

        // decimal points
        do_load(16'h0000, 4'b0100);
        sample("dp2", 2, 3, 4'b1011, 7'b0000001, 1'b0);
        sample("dp1", 1, 3, 4'b1101, 7'b0000001, 1'b1);
        sample("dp2g", 2, 0, 4'b1111, 7'b1111111, 1'b1);

        // disable mid-slot, load while dark, re-enable at digit 0 guard
        wait_frame();
        repeat (12) @(negedge clk);
        enable = 0;
        @(negedge clk);
        chk("dis_an", 32'(an), 32'hF);
        chk("dis_seg", 32'(seg), 32'h7F);
        chk("dis_dp", 32'(dp_n), 32'd1);
        load = 1; value = 16'h9999; dp_in = 4'b0000;
        @(negedge clk); load = 0;
        repeat (2) @(negedge clk);
        chk("dis_ft", 32'(frame_tick), 32'd0);
        enable = 1;
        @(negedge clk);
        chk("ren_g0", 32'(an), 32'hF);
        @(negedge clk);
        chk("ren_g1", 32'(seg), 32'h7F);
        @(negedge clk);
        chk("ren_an", 32'(an), 32'b1110);
        chk("ren_seg", 32'(seg), 32'b0000100);

        // async reset between edges drops a pending load
        wait_frame();
        repeat (12) @(negedge clk);
        chk("pre_rst_an", 32'(an), 32'b1101);
        load = 1; value = 16'hAAAA;
        @(negedge clk); load = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp_n), 32'd1);
        @(negedge clk);
        rst_n = 1;
        sample("post0", 0, 3, 4'b1110, 7'b0000001, 1'b1);
        sample("post3", 3, 3, 4'b0111, 7'b0000001, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
